// File: rtl/rv0_pkg.sv
// Shared types and decode helpers for the rv0 core; this slice carries the LSU pieces.
package rv0_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  function automatic logic [31:0] imm_i(input logic [31:0] insn);
    return {{20{insn[31]}}, insn[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] insn);
    return {{20{insn[31]}}, insn[31:25], insn[11:7]};
  endfunction

  // Illegal width encodings share the misalignment trap so the IDU sees one failure path.
  function automatic logic lsu_bad_access(input logic [2:0] funct3, input logic is_st,
                                          input logic [2:0] ea_lo, input logic xlen64);
    logic legal;
    logic mis;
    if (is_st) legal = (funct3 == LSU_B) || (funct3 == LSU_H) || (funct3 == LSU_W) ||
                       (xlen64 && funct3 == LSU_D);
    else       legal = (funct3 == LSU_B) || (funct3 == LSU_H) || (funct3 == LSU_W) ||
                       (funct3 == LSU_BU) || (funct3 == LSU_HU) ||
                       (xlen64 && (funct3 == LSU_D || funct3 == LSU_WU));
    case (funct3[1:0])
      2'd0:    mis = 1'b0;
      2'd1:    mis = ea_lo[0];
      2'd2:    mis = |ea_lo[1:0];
      default: mis = |ea_lo;
    endcase
    return !legal || mis;
  endfunction

endpackage

// File: rtl/rv_sbuf_if.sv
// Skid-buffer handshake between pipeline stages: source presents rdy plus payload, sink acks.
interface rv_sbuf_if #(
  parameter int XLEN = 32,
  parameter int FLEN = 32
);
  logic [31:0]     insn;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [XLEN-1:0] idata1;
  logic [XLEN-1:0] idata2;
  logic [FLEN-1:0] fdata1;
  logic            rdy;
  logic            ack;

  modport source (output insn, opcode, rd, idata1, idata2, fdata1, rdy, input ack);
  modport sink   (input insn, opcode, rd, idata1, idata2, fdata1, rdy, output ack);
endinterface

// File: rtl/rv0_lsu_align.sv
// Byte-lane steering for the data bus: store shift/byte-enables and load extract/extend.
module rv0_lsu_align
  import rv0_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [1:0]        st_size_i,
  input  logic [OFFW-1:0]   st_off_i,
  input  logic [XLEN-1:0]   st_data_i,
  output logic [XLEN/8-1:0] st_be_o,
  output logic [XLEN-1:0]   st_data_o,
  input  logic [2:0]        ld_funct3_i,
  input  logic [OFFW-1:0]   ld_off_i,
  input  logic [XLEN-1:0]   ld_rdata_i,
  output logic [XLEN-1:0]   ld_data_o
);
  localparam int BEW = XLEN / 8;

  logic [XLEN-1:0] ld_sh;

  assign st_data_o = st_data_i << {st_off_i, 3'b000};
  assign ld_sh     = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    case (st_size_i)
      2'd0:    st_be_o = BEW'(1) << st_off_i;
      2'd1:    st_be_o = BEW'(3) << st_off_i;
      2'd2:    st_be_o = BEW'(15) << st_off_i;
      default: st_be_o = '1;
    endcase
  end

  always_comb begin
    case (ld_funct3_i)
      LSU_B:   ld_data_o = {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      LSU_H:   ld_data_o = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      LSU_W:   ld_data_o = XLEN'(signed'(ld_sh[31:0]));
      LSU_BU:  ld_data_o = XLEN'(ld_sh[7:0]);
      LSU_HU:  ld_data_o = XLEN'(ld_sh[15:0]);
      LSU_WU:  ld_data_o = XLEN'(ld_sh[31:0]);
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/rv0_lsu.sv
// Load/store unit: drains the IDU->MA skid buffer, runs one blocking data-memory access
// at a time and returns load data on the integer write-back port.
module rv0_lsu
  import rv0_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int FLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_flush_i,
  rv_sbuf_if.sink           idu_ma_sbuf_if,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic [4:0]        rfi_waddr_o,
  output logic [XLEN-1:0]   rfi_wdata_o,
  output logic              rfi_we_o,
  output logic              lsu_exc_o,
  output logic              lsu_exc_st_o
);
  localparam int BEW  = XLEN / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int unused_flen = FLEN;

  lsu_state_e      state_q;
  logic            req_q, we_q, st_q, exc_q, exc_st_q, rfi_we_q;
  logic [XLEN-1:0] addr_q, wdata_q, rfi_wdata_q;
  logic [BEW-1:0]  be_q;
  logic [2:0]      funct3_q;
  logic [OFFW-1:0] off_q;
  logic [4:0]      rd_q;

  logic            accept, is_st, bad, unused_sig;
  logic [2:0]      funct3;
  logic [31:0]     imm;
  logic [XLEN-1:0] ea, st_wdata, ld_data;
  logic [BEW-1:0]  st_be;

  assign idu_ma_sbuf_if.ack = (state_q == IDLE) && !lsu_flush_i && !rst_i;
  assign accept = idu_ma_sbuf_if.rdy && idu_ma_sbuf_if.ack;
  assign is_st  = idu_ma_sbuf_if.opcode == OPC_STORE;
  assign funct3 = idu_ma_sbuf_if.insn[14:12];
  // idata2 carries rs2 for stores, so the offset must come from the instruction word.
  assign imm    = is_st ? imm_s(idu_ma_sbuf_if.insn) : imm_i(idu_ma_sbuf_if.insn);
  assign ea     = idu_ma_sbuf_if.idata1 + XLEN'(signed'(imm));
  assign bad    = lsu_bad_access(funct3, is_st, ea[2:0], XLEN == 64);
  assign unused_sig = ^idu_ma_sbuf_if.fdata1;

  rv0_lsu_align #(.XLEN(XLEN), .OFFW(OFFW)) u_align (
    .st_size_i  (funct3[1:0]),
    .st_off_i   (ea[OFFW-1:0]),
    .st_data_i  (idu_ma_sbuf_if.idata2),
    .st_be_o    (st_be),
    .st_data_o  (st_wdata),
    .ld_funct3_i(funct3_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (dmem_rdata_i),
    .ld_data_o  (ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      st_q        <= 1'b0;
      exc_q       <= 1'b0;
      exc_st_q    <= 1'b0;
      rfi_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rfi_wdata_q <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      rd_q        <= '0;
    end else begin
      rfi_we_q <= 1'b0;
      exc_q    <= 1'b0;
      exc_st_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          rd_q     <= idu_ma_sbuf_if.rd;
          funct3_q <= funct3;
          st_q     <= is_st;
          off_q    <= ea[OFFW-1:0];
          if (bad) begin
            // Trapped loads still write back (zero) so the IDU reservation is released.
            exc_q       <= 1'b1;
            exc_st_q    <= is_st;
            rfi_we_q    <= !is_st && (idu_ma_sbuf_if.rd != 5'd0);
            rfi_wdata_q <= '0;
          end else begin
            req_q   <= 1'b1;
            we_q    <= is_st;
            addr_q  <= ea & ~XLEN'(BEW - 1);
            be_q    <= st_be;
            wdata_q <= st_wdata;
            state_q <= REQ;
          end
        end
        REQ: if (dmem_gnt_i) begin
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: if (dmem_rvalid_i) begin
          if (st_q) state_q <= IDLE;
          else begin
            rfi_wdata_q <= ld_data;
            state_q     <= WB;
          end
        end
        WB: begin
          rfi_we_q <= rd_q != 5'd0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign rfi_waddr_o  = rd_q;
  assign rfi_wdata_o  = rfi_wdata_q;
  assign rfi_we_o     = rfi_we_q;
  assign lsu_exc_o    = exc_q;
  assign lsu_exc_st_o = exc_st_q;

endmodule

// File: tb/tb_rv0_lsu.sv
// Directed bench for rv0_lsu (XLEN=32) with a small zero-wait bus model.
module tb_rv0_lsu;
  import rv0_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, rfi_wdata;
  logic [3:0]  dmem_be;
  logic [4:0]  rfi_waddr;
  logic        rfi_we, exc, exc_st;
  logic        gnt_block = 1'b0;
  logic        rv_hold = 1'b0;
  logic        pend = 1'b0;
  int          checks = 0;
  int          errors = 0;

  rv_sbuf_if #(.XLEN(32), .FLEN(32)) sbuf ();

  rv0_lsu #(.XLEN(32), .FLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .lsu_flush_i(flush), .idu_ma_sbuf_if(sbuf),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata), .dmem_gnt_i(dmem_gnt),
    .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .rfi_waddr_o(rfi_waddr), .rfi_wdata_o(rfi_wdata), .rfi_we_o(rfi_we),
    .lsu_exc_o(exc), .lsu_exc_st_o(exc_st)
  );

  always #5 clk = ~clk;

  assign dmem_gnt    = dmem_req && !gnt_block;
  assign dmem_rvalid = pend && !rv_hold;
  always @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else if (dmem_req && dmem_gnt) pend <= 1'b1;
    else if (dmem_rvalid) pend <= 1'b0;
  end

  function automatic logic [31:0] enc_ld(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, OPC_LOAD};
  endfunction

  function automatic logic [31:0] enc_st(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], OPC_STORE};
  endfunction

  task automatic drive(input logic [31:0] insn, input logic [6:0] opc, input logic [4:0] rd,
                       input logic [31:0] a1, input logic [31:0] a2);
    sbuf.insn = insn; sbuf.opcode = opc; sbuf.rd = rd;
    sbuf.idata1 = a1; sbuf.idata2 = a2; sbuf.rdy = 1'b1;
  endtask

  // Presents one transaction for a single edge; returns at the negedge after accept.
  task automatic accept(input logic [31:0] insn, input logic [6:0] opc, input logic [4:0] rd,
                        input logic [31:0] a1, input logic [31:0] a2);
    @(negedge clk);
    drive(insn, opc, rd, a1, a2);
    @(negedge clk);
    sbuf.rdy = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sbuf.ack, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, rfi_waddr, rfi_wdata,
         rfi_we, exc, exc_st} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b req=%b we=%b addr=%h be=%h wdata=%h waddr=%0d rwdata=%h rwe=%b exc=%b exc_st=%b, all required 0",
               sbuf.ack, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, rfi_waddr,
               rfi_wdata, rfi_we, exc, exc_st);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sbuf.ack !== 1'b1) begin
      errors++; $display("FAIL reset_release_ack: ack=%b required 1", sbuf.ack);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [6]  = '{LSU_W, LSU_B, LSU_BU, LSU_H, LSU_HU, LSU_B};
    logic [11:0] imm [6] = '{12'd4, 12'd3, 12'd3, 12'd2, 12'hFFE, 12'd1};
    logic [4:0]  rd [6]  = '{5'd5, 5'd6, 5'd6, 5'd8, 5'd9, 5'd3};
    logic [31:0] rdat [6] = '{32'hDEADBEEF, 32'h80112233, 32'h80112233, 32'h80112233,
                              32'h7FFE1111, 32'h00004A00};
    logic [31:0] eaddr [6] = '{32'h1004, 32'h1000, 32'h1000, 32'h1000, 32'h0FFC, 32'h1000};
    logic [3:0]  ebe [6]  = '{4'hF, 4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010};
    logic [31:0] ewd [6]  = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8011,
                              32'h00007FFE, 32'h0000004A};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      dmem_rdata = rdat[i];
      accept(enc_ld(imm[i], f3[i], rd[i]), OPC_LOAD, rd[i], 32'h1000, 32'h0);
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== eaddr[i] || dmem_be !== ebe[i]) begin
        errors++;
        $display("FAIL load%0d_req: req=%b we=%b addr=%h be=%b required 1 0 %h %b",
                 i, dmem_req, dmem_we, dmem_addr, dmem_be, eaddr[i], ebe[i]);
      end
      cyc = 1;
      while (rfi_we !== 1'b1 && cyc < 12) begin
        @(negedge clk); cyc++;
      end
      checks++;
      if (rfi_we !== 1'b1 || cyc != 4 || rfi_waddr !== rd[i] || rfi_wdata !== ewd[i]) begin
        errors++;
        $display("FAIL load%0d_wb: we=%b cycle=%0d waddr=%0d wdata=%h required 1 4 %0d %h",
                 i, rfi_we, cyc, rfi_waddr, rfi_wdata, rd[i], ewd[i]);
      end
      @(negedge clk);
      checks++;
      if (rfi_we !== 1'b0 || sbuf.ack !== 1'b1) begin
        errors++;
        $display("FAIL load%0d_pulse: we=%b ack=%b required 0 1", i, rfi_we, sbuf.ack);
      end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3 [4]  = '{LSU_H, LSU_B, LSU_W, LSU_B};
    logic [11:0] imm [4] = '{12'd2, 12'hFFF, 12'd12, 12'd2};
    logic [31:0] a1 [4]  = '{32'h1000, 32'h1001, 32'h1000, 32'h1000};
    logic [31:0] a2 [4]  = '{32'hABCD1234, 32'hABCD1234, 32'hCAFEF00D, 32'h000000A5};
    logic [31:0] eaddr [4] = '{32'h1000, 32'h1000, 32'h100C, 32'h1000};
    logic [3:0]  ebe [4]  = '{4'b1100, 4'b0001, 4'hF, 4'b0100};
    logic [31:0] ewd [4]  = '{32'h12340000, 32'h00000034, 32'hCAFEF00D, 32'h00A50000};
    logic [31:0] mask;
    logic        saw_we;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      accept(enc_st(imm[i], f3[i]), OPC_STORE, 5'd0, a1[i], a2[i]);
      mask = {{8{ebe[i][3]}}, {8{ebe[i][2]}}, {8{ebe[i][1]}}, {8{ebe[i][0]}}};
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== eaddr[i] ||
          dmem_be !== ebe[i] || (dmem_wdata & mask) !== ewd[i]) begin
        errors++;
        $display("FAIL store%0d_req: req=%b we=%b addr=%h be=%b wdata=%h required 1 1 %h %b %h(lanes)",
                 i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, eaddr[i], ebe[i], ewd[i]);
      end
      saw_we = 1'b0;
      cyc = 1;
      while (sbuf.ack !== 1'b1 && cyc < 12) begin
        @(negedge clk); cyc++;
        if (rfi_we === 1'b1) saw_we = 1'b1;
      end
      repeat (3) begin
        @(negedge clk);
        if (rfi_we === 1'b1) saw_we = 1'b1;
      end
      checks++;
      if (sbuf.ack !== 1'b1 || saw_we || dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL store%0d_done: ack=%b rfi_we_seen=%b req=%b required 1 0 0",
                 i, sbuf.ack, saw_we, dmem_req);
      end
    end
  endtask

  task automatic test_misaligned();
    logic        st [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [6]  = '{LSU_W, LSU_W, LSU_H, LSU_D, LSU_BU, LSU_W};
    logic [11:0] imm [6] = '{12'd1, 12'd2, 12'd3, 12'd0, 12'd0, 12'd1};
    logic [4:0]  rd [6]  = '{5'd7, 5'd0, 5'd4, 5'd11, 5'd0, 5'd0};
    logic        ewe [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (st[i]) accept(enc_st(imm[i], f3[i]), OPC_STORE, rd[i], 32'h1000, 32'h55AA55AA);
      else       accept(enc_ld(imm[i], f3[i], rd[i]), OPC_LOAD, rd[i], 32'h1000, 32'h0);
      checks++;
      if (exc !== 1'b1 || exc_st !== st[i] || rfi_we !== ewe[i] || dmem_req !== 1'b0 ||
          (ewe[i] && (rfi_waddr !== rd[i] || rfi_wdata !== 32'h0))) begin
        errors++;
        $display("FAIL exc%0d_pulse: exc=%b st=%b rfi_we=%b req=%b waddr=%0d wdata=%h required 1 %b %b 0 %0d 0",
                 i, exc, exc_st, rfi_we, dmem_req, rfi_waddr, rfi_wdata, st[i], ewe[i], rd[i]);
      end
      @(negedge clk);
      checks++;
      if (exc !== 1'b0 || rfi_we !== 1'b0 || dmem_req !== 1'b0 || sbuf.ack !== 1'b1) begin
        errors++;
        $display("FAIL exc%0d_after: exc=%b rfi_we=%b req=%b ack=%b required 0 0 0 1",
                 i, exc, rfi_we, dmem_req, sbuf.ack);
      end
    end
  endtask

  task automatic test_gnt_stall();
    int cyc;
    gnt_block = 1'b1;
    accept(enc_st(12'd8, LSU_W), OPC_STORE, 5'd0, 32'h1000, 32'h5A5AA5A5);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h1008 ||
          dmem_be !== 4'hF || dmem_wdata !== 32'h5A5AA5A5 || sbuf.ack !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: req=%b we=%b addr=%h be=%h wdata=%h ack=%b required 1 1 00001008 f 5a5aa5a5 0",
                 c, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, sbuf.ack);
      end
      @(negedge clk);
    end
    gnt_block = 1'b0;
    cyc = 0;
    while (sbuf.ack !== 1'b1 && cyc < 10) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (sbuf.ack !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_complete: ack=%b req=%b after %0d cycles, required 1 0", sbuf.ack, dmem_req, cyc);
    end
  endtask

  task automatic test_x0_load();
    logic saw_we;
    dmem_rdata = 32'h11111111;
    accept(enc_ld(12'd0, LSU_W, 5'd0), OPC_LOAD, 5'd0, 32'h1000, 32'h0);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL x0_req: req=%b required 1", dmem_req);
    end
    saw_we = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rfi_we === 1'b1) saw_we = 1'b1;
    end
    checks++;
    if (saw_we || sbuf.ack !== 1'b1) begin
      errors++; $display("FAIL x0_no_wb: rfi_we_seen=%b ack=%b required 0 1", saw_we, sbuf.ack);
    end
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    rv_hold = 1'b1;
    accept(enc_ld(12'd0, LSU_W, 5'd10), OPC_LOAD, 5'd10, 32'h1000, 32'h0);
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || sbuf.ack !== 1'b0) begin
      errors++; $display("FAIL rstwait_in_wait: req=%b ack=%b required 0 0", dmem_req, sbuf.ack);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sbuf.ack !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL rstwait_during: ack=%b req=%b required 0 0", sbuf.ack, dmem_req);
    end
    rst = 1'b0;
    rv_hold = 1'b0;
    #1;
    checks++;
    if (sbuf.ack !== 1'b1) begin
      errors++; $display("FAIL rstwait_idle_ack: ack=%b required 1", sbuf.ack);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rfi_we === 1'b1 || exc === 1'b1 || dmem_req === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL rstwait_quiet: activity_seen=%b required 0", seen);
    end
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk);
    flush = 1'b1;
    drive(enc_ld(12'd0, LSU_W, 5'd13), OPC_LOAD, 5'd13, 32'h1000, 32'h0);
    #1;
    checks++;
    if (sbuf.ack !== 1'b0) begin
      errors++; $display("FAIL flush_ack: ack=%b required 0", sbuf.ack);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dmem_req === 1'b1 || rfi_we === 1'b1 || exc === 1'b1) seen = 1'b1;
    end
    sbuf.rdy = 1'b0;
    flush = 1'b0;
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush_no_accept: activity_seen=%b required 0", seen);
    end
  endtask

  task automatic test_flush_inflight();
    int cyc;
    dmem_rdata = 32'h0BADF00D;
    accept(enc_ld(12'd0, LSU_W, 5'd12), OPC_LOAD, 5'd12, 32'h2000, 32'h0);
    flush = 1'b1;
    cyc = 1;
    while (rfi_we !== 1'b1 && cyc < 12) begin
      @(negedge clk); cyc++;
    end
    flush = 1'b0;
    checks++;
    if (rfi_we !== 1'b1 || cyc != 4 || rfi_waddr !== 5'd12 || rfi_wdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL flush_inflight_wb: we=%b cycle=%0d waddr=%0d wdata=%h required 1 4 12 0badf00d",
               rfi_we, cyc, rfi_waddr, rfi_wdata);
    end
  endtask

  initial begin
    sbuf.insn = '0; sbuf.opcode = '0; sbuf.rd = '0; sbuf.idata1 = '0;
    sbuf.idata2 = '0; sbuf.fdata1 = '0; sbuf.rdy = 1'b0;
    dmem_rdata = '0;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_gnt_stall();
    test_x0_load();
    test_reset_in_wait();
    test_flush();
    test_flush_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
